// File: rtl/idex_operand_stage_pkg.sv
// rtl/idex_operand_stage_pkg.sv - datapath width, operand select encodings and ALU op codes
package idex_operand_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SRC_A_RS1   = 2'b00,
        SRC_A_PC    = 2'b01,
        SRC_A_ZERO  = 2'b10,
        SRC_A_ZERO2 = 2'b11
    } src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2   = 2'b00,
        SRC_B_IMM   = 2'b01,
        SRC_B_FOUR  = 2'b10,
        SRC_B_ZERO  = 2'b11
    } src_b_e;

    localparam logic [3:0] ALU_ADD = 4'b0000;

endpackage

// File: rtl/idex_operand_stage_if.sv
// rtl/idex_operand_stage_if.sv - decode, forwarding and EX-side signals of the ID/EX stage
interface idex_operand_stage_if;
    import idex_operand_stage_pkg::*;

    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_imm;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [1:0]      id_src_a;
    logic [1:0]      id_src_b;
    logic [3:0]      id_alu_control;
    logic            id_reg_write;
    logic            exmem_reg_write;
    logic [4:0]      exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [4:0]      memwb_rd;
    logic [XLEN-1:0] memwb_result;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_valid;
    logic            ex_reg_write;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_pc;

    modport master (
        output stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_src_a, id_src_b, id_alu_control, id_reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  operand_a, operand_b, alu_control, ex_store_data,
               ex_valid, ex_reg_write, ex_rd, ex_pc
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
               id_rs1, id_rs2, id_rd, id_src_a, id_src_b, id_alu_control, id_reg_write,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output operand_a, operand_b, alu_control, ex_store_data,
               ex_valid, ex_reg_write, ex_rd, ex_pc
    );

endinterface

// File: rtl/idex_operand_stage_forward_mux.sv
// rtl/idex_operand_stage_forward_mux.sv - 3-way priority forward select: EX/MEM, MEM/WB, stored data
module idex_operand_stage_forward_mux
    import idex_operand_stage_pkg::*;
(
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic            exmem_reg_write,
    input  logic [4:0]      exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [4:0]      memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] data
);

    logic exmem_hit;
    logic memwb_hit;

    // x0 is hardwired zero, so a write targeting it must never be forwarded
    assign exmem_hit = exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs);
    assign memwb_hit = memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs);

    always_comb begin
        data = reg_data;
        if (exmem_hit) begin
            data = exmem_result;
        end else if (memwb_hit) begin
            data = memwb_result;
        end
    end

endmodule

// File: rtl/idex_operand_stage.sv
// rtl/idex_operand_stage.sv - ID/EX pipeline register with operand forwarding and select muxes
module idex_operand_stage
    import idex_operand_stage_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    idex_operand_stage_if.slave bus
);

    logic            ex_valid_q;
    logic            ex_reg_write_q;
    logic [4:0]      ex_rd_q;
    logic [4:0]      ex_rs1_q;
    logic [4:0]      ex_rs2_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [XLEN-1:0] ex_imm_q;
    logic [XLEN-1:0] ex_rs1_data_q;
    logic [XLEN-1:0] ex_rs2_data_q;
    logic [1:0]      ex_src_a_q;
    logic [1:0]      ex_src_b_q;
    logic [3:0]      ex_alu_control_q;

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic [XLEN-1:0] id_rs1_bypass;
    logic [XLEN-1:0] id_rs2_bypass;

    idex_operand_stage_forward_mux u_fwd1 (
        .rs(ex_rs1_q), .reg_data(ex_rs1_data_q),
        .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(fwd1)
    );

    idex_operand_stage_forward_mux u_fwd2 (
        .rs(ex_rs2_q), .reg_data(ex_rs2_data_q),
        .exmem_reg_write(bus.exmem_reg_write), .exmem_rd(bus.exmem_rd), .exmem_result(bus.exmem_result),
        .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(fwd2)
    );

    // Decode bypass: the regfile write from MEM/WB lands this same edge, so its data is stale in ID
    idex_operand_stage_forward_mux u_byp1 (
        .rs(bus.id_rs1), .reg_data(bus.id_rs1_data),
        .exmem_reg_write(1'b0), .exmem_rd(5'd0), .exmem_result('0),
        .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(id_rs1_bypass)
    );

    idex_operand_stage_forward_mux u_byp2 (
        .rs(bus.id_rs2), .reg_data(bus.id_rs2_data),
        .exmem_reg_write(1'b0), .exmem_rd(5'd0), .exmem_result('0),
        .memwb_reg_write(bus.memwb_reg_write), .memwb_rd(bus.memwb_rd), .memwb_result(bus.memwb_result),
        .data(id_rs2_bypass)
    );

    always_ff @(posedge clk) begin
        if (!reset_n || bus.flush) begin
            ex_valid_q       <= 1'b0;
            ex_reg_write_q   <= 1'b0;
            ex_rd_q          <= 5'd0;
            ex_rs1_q         <= 5'd0;
            ex_rs2_q         <= 5'd0;
            ex_pc_q          <= '0;
            ex_imm_q         <= '0;
            ex_rs1_data_q    <= '0;
            ex_rs2_data_q    <= '0;
            ex_src_a_q       <= 2'b00;
            ex_src_b_q       <= 2'b00;
            ex_alu_control_q <= ALU_ADD;
        end else if (bus.stall) begin
            // Refresh held operands so a producer retiring during the stall is not lost
            ex_rs1_data_q <= fwd1;
            ex_rs2_data_q <= fwd2;
        end else begin
            ex_valid_q       <= bus.id_valid;
            ex_reg_write_q   <= bus.id_reg_write && bus.id_valid;
            ex_rd_q          <= bus.id_rd;
            ex_rs1_q         <= bus.id_rs1;
            ex_rs2_q         <= bus.id_rs2;
            ex_pc_q          <= bus.id_pc;
            ex_imm_q         <= bus.id_imm;
            ex_rs1_data_q    <= id_rs1_bypass;
            ex_rs2_data_q    <= id_rs2_bypass;
            ex_src_a_q       <= bus.id_src_a;
            ex_src_b_q       <= bus.id_src_b;
            ex_alu_control_q <= bus.id_alu_control;
        end
    end

    always_comb begin
        bus.operand_a = '0;
        case (ex_src_a_q)
            SRC_A_RS1: bus.operand_a = fwd1;
            SRC_A_PC:  bus.operand_a = ex_pc_q;
            default:   bus.operand_a = '0;
        endcase
    end

    always_comb begin
        bus.operand_b = '0;
        case (ex_src_b_q)
            SRC_B_RS2:  bus.operand_b = fwd2;
            SRC_B_IMM:  bus.operand_b = ex_imm_q;
            SRC_B_FOUR: bus.operand_b = XLEN'(4);
            default:    bus.operand_b = '0;
        endcase
    end

    assign bus.ex_store_data = fwd2;
    assign bus.alu_control   = ex_alu_control_q;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_pc         = ex_pc_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// tb/tb_idex_operand_stage.sv - directed and randomized checks against a behavioural reference model
module tb_idex_operand_stage;
    import idex_operand_stage_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    idex_operand_stage_if bus ();

    idex_operand_stage dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model of the instruction currently sitting in EX
    logic            m_valid, m_rw;
    logic [4:0]      m_rd, m_rs1, m_rs2;
    logic [XLEN-1:0] m_pc, m_imm, m_d1, m_d2;
    logic [1:0]      m_sa, m_sb;
    logic [3:0]      m_alu;

    function automatic logic [XLEN-1:0] value_of(input logic [4:0] rs, input logic [XLEN-1:0] stored,
                                                 input bit use_exmem);
        if (use_exmem && bus.exmem_reg_write && bus.exmem_rd == rs && rs != 0) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == rs && rs != 0) return bus.memwb_result;
        return stored;
    endfunction

    function automatic logic [XLEN-1:0] exp_a();
        if (m_sa == 2'd0) return value_of(m_rs1, m_d1, 1'b1);
        if (m_sa == 2'd1) return m_pc;
        return '0;
    endfunction

    function automatic logic [XLEN-1:0] exp_b();
        if (m_sb == 2'd0) return value_of(m_rs2, m_d2, 1'b1);
        if (m_sb == 2'd1) return m_imm;
        if (m_sb == 2'd2) return XLEN'(4);
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".operand_a"},     bus.operand_a,                exp_a());
        chk({tag, ".operand_b"},     bus.operand_b,                exp_b());
        chk({tag, ".store_data"},    bus.ex_store_data,            value_of(m_rs2, m_d2, 1'b1));
        chk({tag, ".alu_control"},   XLEN'(bus.alu_control),       XLEN'(m_alu));
        chk({tag, ".ex_valid"},      XLEN'(bus.ex_valid),          XLEN'(m_valid));
        chk({tag, ".ex_reg_write"},  XLEN'(bus.ex_reg_write),      XLEN'(m_rw));
        chk({tag, ".ex_rd"},         XLEN'(bus.ex_rd),             XLEN'(m_rd));
        chk({tag, ".ex_pc"},         bus.ex_pc,                    m_pc);
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic [XLEN-1:0] n1, n2;
        if (!reset_n || bus.flush) begin
            {m_valid, m_rw, m_rd, m_rs1, m_rs2} = '0;
            {m_pc, m_imm, m_d1, m_d2, m_sa, m_sb, m_alu} = '0;
        end else if (bus.stall) begin
            n1 = value_of(m_rs1, m_d1, 1'b1);
            n2 = value_of(m_rs2, m_d2, 1'b1);
            m_d1 = n1;
            m_d2 = n2;
        end else begin
            m_valid = bus.id_valid;
            m_rw    = bus.id_valid && bus.id_reg_write;
            m_rd    = bus.id_rd;
            m_rs1   = bus.id_rs1;
            m_rs2   = bus.id_rs2;
            m_pc    = bus.id_pc;
            m_imm   = bus.id_imm;
            m_d1    = value_of(bus.id_rs1, bus.id_rs1_data, 1'b0);
            m_d2    = value_of(bus.id_rs2, bus.id_rs2_data, 1'b0);
            m_sa    = bus.id_src_a;
            m_sb    = bus.id_src_b;
            m_alu   = bus.id_alu_control;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_pc = '0; bus.id_imm = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_src_a = 0; bus.id_src_b = 0; bus.id_alu_control = 0; bus.id_reg_write = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = '0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = '0;
    endtask

    initial begin
        reset_n = 1;
        idle_inputs();
        {m_valid, m_rw, m_rd, m_rs1, m_rs2} = '0;
        {m_pc, m_imm, m_d1, m_d2, m_sa, m_sb, m_alu} = '0;
        @(posedge clk); #1;

        // Load something non-zero, then reset while stalled
        bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 4; bus.id_pc = 32'h40;
        bus.id_alu_control = 4'b0110; bus.id_src_a = 1; bus.id_src_b = 1; bus.id_imm = 32'h9;
        tick();
        bus.stall = 1; reset_n = 0;
        tick();
        reset_n = 1;
        check_all("reset_mid_stall");
        chk("reset.operand_a_zero", bus.operand_a, '0);
        chk("reset.alu_zero", XLEN'(bus.alu_control), '0);
        idle_inputs();

        // EX/MEM beats MEM/WB on the same rd
        bus.id_valid = 1; bus.id_rs1 = 5; bus.id_rs1_data = 32'h99; bus.id_src_a = 0;
        tick();
        idle_inputs();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 32'h11;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'h22;
        #1;
        chk("prio.exmem", bus.operand_a, 32'h11);
        bus.exmem_reg_write = 0;
        #1;
        chk("prio.memwb", bus.operand_a, 32'h22);
        check_all("prio");
        idle_inputs();

        // x0 is never forwarded
        bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs1_data = '0;
        tick();
        idle_inputs();
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'hDEAD;
        #1;
        chk("x0.operand_a", bus.operand_a, '0);
        idle_inputs();

        // Stall refresh keeps a MEM/WB value after it retires
        bus.id_valid = 1; bus.id_rs2 = 7; bus.id_src_b = 0;
        tick();
        idle_inputs();
        bus.memwb_reg_write = 1; bus.memwb_rd = 7; bus.memwb_result = 32'h55;
        #1;
        chk("refresh.before", bus.operand_b, 32'h55);
        bus.stall = 1;
        tick();
        bus.memwb_rd = 9; bus.memwb_result = 32'h66;
        #1;
        chk("refresh.stall1", bus.operand_b, 32'h55);
        tick();
        chk("refresh.stall2", bus.operand_b, 32'h55);
        check_all("refresh");
        idle_inputs();

        // Flush wins over stall
        bus.id_valid = 1; bus.id_reg_write = 1; bus.id_rd = 12; bus.id_rs1 = 1; bus.id_rs1_data = 32'hAB;
        bus.id_rs2 = 2; bus.id_rs2_data = 32'hCD;
        tick();
        bus.stall = 1; bus.flush = 1;
        tick();
        idle_inputs();
        #1;
        chk("flush.ex_valid", XLEN'(bus.ex_valid), '0);
        chk("flush.ex_reg_write", XLEN'(bus.ex_reg_write), '0);
        chk("flush.operand_a", bus.operand_a, '0);
        chk("flush.operand_b", bus.operand_b, '0);

        // Decode bypass from MEM/WB at capture
        bus.id_valid = 1; bus.id_rs1 = 3; bus.id_rs1_data = 32'h01; bus.id_src_a = 0;
        bus.memwb_reg_write = 1; bus.memwb_rd = 3; bus.memwb_result = 32'h77;
        tick();
        idle_inputs();
        #1;
        chk("bypass.operand_a", bus.operand_a, 32'h77);

        // pc and constant-4 selects
        bus.id_valid = 1; bus.id_src_a = 1; bus.id_src_b = 2; bus.id_pc = 32'h100;
        tick();
        chk("select.operand_a", bus.operand_a, 32'h100);
        chk("select.operand_b", bus.operand_b, 32'h4);
        check_all("select");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset_n             = ($urandom_range(0, 39) != 0);
            bus.stall           = ($urandom_range(0, 3) == 0);
            bus.flush           = ($urandom_range(0, 9) == 0);
            bus.id_valid        = 1'($urandom);
            bus.id_pc           = $urandom;
            bus.id_imm          = $urandom;
            bus.id_rs1_data     = $urandom;
            bus.id_rs2_data     = $urandom;
            bus.id_rs1          = 5'($urandom_range(0, 7));
            bus.id_rs2          = 5'($urandom_range(0, 7));
            bus.id_rd           = 5'($urandom_range(0, 31));
            bus.id_src_a        = 2'($urandom);
            bus.id_src_b        = 2'($urandom);
            bus.id_alu_control  = 4'($urandom);
            bus.id_reg_write    = 1'($urandom);
            bus.exmem_reg_write = 1'($urandom);
            bus.exmem_rd        = 5'($urandom_range(0, 7));
            bus.exmem_result    = $urandom;
            bus.memwb_reg_write = 1'($urandom);
            bus.memwb_rd        = 5'($urandom_range(0, 7));
            bus.memwb_result    = $urandom;
            #1;
            check_all("random");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

ID/EX pipeline register and operand-forwarding stage for the RV1 core. Captures decoded instruction fields at the ID→EX boundary. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB. Drives the final `operand_a`, `operand_b` and `alu_control` into the EX-stage ALU; supports stall (hold), flush (bubble), and operand refresh while stalled.

## Interface
- `XLEN`, `` `XLEN `` (32), datapath width; 32 or 64.
- `clk`  input  1  core clock; all state updates on rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `stall`  input  1  hold current ID/EX contents (from hazard unit).
- `flush`  input  1  replace ID/EX contents with a bubble; priority over `stall`.
- `id_valid`  input  1  decode slot holds a real instruction.
- `id_pc`, `id_imm`, `id_rs1_data`, `id_rs2_data`  input  XLEN  decode-stage values.
- `id_rs1`, `id_rs2`, `id_rd`  input  5  register indices.
- `id_src_a`, `id_src_b`  input  2  operand selects (encodings under Operation).
- `id_alu_control`  input  4  ALU op code, passed through unchanged.
- `id_reg_write`  input  1  instruction writes `rd`.
- `exmem_reg_write`  input  1  EX/MEM will write back.
- `exmem_rd`  input  5  EX/MEM destination.
- `exmem_result`  input  XLEN  EX/MEM value.
- `memwb_reg_write`  input  1  MEM/WB will write back.
- `memwb_rd`  input  5  MEM/WB destination.
- `memwb_result`  input  XLEN  MEM/WB value.
- `operand_a`, `operand_b`  output  XLEN  to ALU.
- `alu_control`  output  4  to ALU.
- `ex_store_data`  output  XLEN  forwarded rs2 value for stores.
- `ex_valid`, `ex_reg_write`  output  1  registered; `ex_reg_write` is 0 whenever `ex_valid` is 0.
- `ex_rd`  output  5  registered destination.
- `ex_pc`  output  XLEN  registered PC, for branch target logic.

## Operation
- Selects:
  - `src_a`: 00 = rs1, 01 = pc, 10 = zero, 11 = zero.
  - `src_b`: 00 = rs2, 01 = imm, 10 = constant 4, 11 = zero.
- Forward match: `reg_write && rd != 0 && rd == rsN`. Priority is EX/MEM, then MEM/WB, then the registered data. x0 is never forwarded.
- The forwarded rs1 and rs2 values (`fwd1`, `fwd2`) are combinational from the registered state and the current pipeline inputs. `operand_a`, `operand_b` and `ex_store_data` apply the selects to these values.
- Capture cycle (`!stall && !flush`):
  - Load all `id_*` fields.
  - `ex_valid <= id_valid`.
  - `ex_reg_write <= id_reg_write && id_valid`.
  - Decode bypass: if MEM/WB matches `id_rs1` (or `id_rs2`), capture `memwb_result` instead of the regfile data.
- Stall cycle (`stall && !flush`):
  - Control fields, indices and pc hold.
  - Stored rs1 and rs2 data are overwritten with `fwd1` and `fwd2`. A producer that retires from MEM/WB during the stall is therefore not lost.
- Flush cycle: `ex_valid`, `ex_reg_write` and `ex_rd` go to 0, `alu_control` goes to 4'b0000 (ADD), and all data goes to 0. Flush wins over a simultaneous stall.
- Reset (`!reset_n` at the edge): every register is 0.
  - Outputs after reset: `ex_valid`, `ex_reg_write`, `ex_rd` = 0; `alu_control` = 4'b0000; `ex_pc`, `operand_a`, `operand_b`, `ex_store_data` = 0.
  - Reset overrides stall and flush, including mid-stall.
- Same `rd` in EX/MEM and MEM/WB: the EX/MEM (younger) value is used.

## Timing
- ID→EX latency is 1 cycle. Fields presented at edge N appear on the outputs after edge N.
- Forwarding is combinational, with zero added latency. The path is EX/MEM or MEM/WB mux, then select mux, then ALU, and must fit in the EX cycle.
- A load-use hazard is resolved by the hazard unit asserting `stall` for 1 cycle; this block needs no load awareness.
- Bubbles are only created by `flush`. `stall` never creates a bubble; downstream gating on `ex_valid` is the hazard unit's responsibility.

## Structure
- Shared header `config/rv_config.vh`: `XLEN`.
- Shared header `rv_pipeline_defs.vh`: `SRC_A_*`/`SRC_B_*` encodings and ALU op codes (ADD = 0000 used for bubbles).
- Sub-module `forward_mux`: a 3-way priority forward select. It is instantiated twice and reused for the decode bypass with the EX/MEM inputs tied off.

## Test plan
- **Reset mid-stall**: with `stall = 1` and `id_valid = 1`, assert `reset_n = 0` for 1 edge → all outputs 0 and `alu_control` = 0000 on the next cycle.
- **EX/MEM priority**: EX/MEM `rd` = 5 with 0x11; MEM/WB `rd` = 5 with 0x22; EX `rs1` = 5, `src_a` = 00 → `operand_a` = 0x11. Drop EX/MEM write → `operand_a` = 0x22.
- **x0 suppression**: EX/MEM `rd` = 0 with 0xDEAD, `rs1` = 0, registered data 0 → `operand_a` = 0.
- **Stall refresh**: MEM/WB `rd` = 7 with 0x55 forwards into held `rs2` = 7. Stall for 2 cycles while MEM/WB moves to `rd` = 9 → `operand_b` remains 0x55.
- **Flush over stall**: `stall` = `flush` = 1 with a valid instruction held → next cycle `ex_valid` = 0, `ex_reg_write` = 0, `operand_a` = `operand_b` = 0.
- **Decode bypass and selects**:
  - At capture, MEM/WB writes `rd` = 3 with 0x77; `id_rs1` = 3 with stale regfile data 0x01 → after the edge, with no forward active, `operand_a` = 0x77.
  - `src_a` = 01, `src_b` = 10, `id_pc` = 0x100 → `operand_a` = 0x100 and `operand_b` = 4.
